// File: rtl/rom_task_fetcher.sv
// rom_task_fetcher: assembles 26-bit task words from a byte-wide ROM and hands them
// alternately to two core-set ports, holding each word until its port acknowledges.
module rom_task_fetcher #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 26,
    parameter int CNT_W  = 8
) (
    input  logic              medClk,
    input  logic              rstN,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [CNT_W-1:0]  wordCount,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [7:0]        romData,
    output logic [WORD_W-1:0] rData_port_0,
    output logic [WORD_W-1:0] rData_port_1,
    output logic              valid_0,
    output logic              valid_1,
    input  logic              ack_0,
    input  logic              ack_1,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, LOAD, HOLD, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rom_addr_q, rom_addr_d;
    logic [1:0] idx_q, idx_d, sidx_q, sidx_d;
    logic samp_q, samp_d, ptr_q, ptr_d, vld0_q, vld0_d, vld1_q, vld1_d;
    logic [WORD_W-1:0] word_q, word_d, data0_q, data0_d, data1_q, data1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ack_sel;
    assign ack_sel      = ptr_q ? ack_1 : ack_0;
    assign romAddr      = rom_addr_q;
    assign rData_port_0 = data0_q;
    assign rData_port_1 = data1_q;
    assign valid_0      = vld0_q;
    assign valid_1      = vld1_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rom_addr_d = rom_addr_q;
        idx_d      = idx_q;
        sidx_d     = sidx_q;
        samp_d     = 1'b0;
        ptr_d      = ptr_q;
        vld0_d     = vld0_q;
        vld1_d     = vld1_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        cnt_d      = cnt_q;
        // romData answers the address issued on the previous edge
        word_d = !samp_q        ? word_q :
                 sidx_q == 2'd0 ? {romData[1:0], word_q[23:0]} :
                 sidx_q == 2'd1 ? {word_q[25:24], romData, word_q[15:0]} :
                 sidx_q == 2'd2 ? {word_q[25:16], romData, word_q[7:0]} :
                                  {word_q[25:8], romData};
        case (state_q)
            IDLE: if (start) begin
                addr_d  = baseAddr;
                cnt_d   = wordCount;
                ptr_d   = 1'b0;
                idx_d   = 2'd0;
                state_d = wordCount == '0 ? DONE : FETCH;
            end
            FETCH: begin
                rom_addr_d = addr_q;
                addr_d     = addr_q + 1'b1;
                samp_d     = 1'b1;
                sidx_d     = idx_q;
                idx_d      = idx_q + 2'd1;
                state_d    = idx_q == 2'd3 ? CAPTURE : FETCH;
            end
            CAPTURE: state_d = LOAD;
            LOAD: begin
                data0_d = ptr_q ? data0_q : word_q;
                data1_d = ptr_q ? word_q : data1_q;
                vld0_d  = vld0_q | ~ptr_q;
                vld1_d  = vld1_q | ptr_q;
                state_d = HOLD;
            end
            HOLD: if (ack_sel) begin
                vld0_d  = ptr_q ? vld0_q : 1'b0;
                vld1_d  = ptr_q ? 1'b0 : vld1_q;
                ptr_d   = ~ptr_q;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CNT_W'(1) ? DONE : FETCH;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge medClk) begin
        if (!rstN) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rom_addr_q <= '0;
            idx_q      <= '0;
            sidx_q     <= '0;
            samp_q     <= 1'b0;
            ptr_q      <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            word_q     <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rom_addr_q <= rom_addr_d;
            idx_q      <= idx_d;
            sidx_q     <= sidx_d;
            samp_q     <= samp_d;
            ptr_q      <= ptr_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            word_q     <= word_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rom_task_fetcher.sv
// tb_rom_task_fetcher: directed scenario tests for rom_task_fetcher against a ROM
// whose data is present at the edge following each address.
module tb_rom_task_fetcher;
    logic        medClk = 1'b0;
    logic        rstN, start, ack_0, ack_1;
    logic [15:0] baseAddr, romAddr;
    logic [7:0]  wordCount, romData;
    logic [25:0] rData_port_0, rData_port_1;
    logic        valid_0, valid_1, busy, done;
    logic [7:0]  rom [0:65535];
    int          tests_run = 0;
    int          failed = 0;
    logic        v1_seen, mon_en;
    logic [26:0] mon_log [$];

    rom_task_fetcher dut (
        .medClk(medClk), .rstN(rstN), .start(start), .baseAddr(baseAddr),
        .wordCount(wordCount), .romAddr(romAddr), .romData(romData),
        .rData_port_0(rData_port_0), .rData_port_1(rData_port_1),
        .valid_0(valid_0), .valid_1(valid_1), .ack_0(ack_0), .ack_1(ack_1),
        .busy(busy), .done(done)
    );

    always #5 medClk = ~medClk;
    assign romData = rom[romAddr];

    always @(negedge medClk) begin
        if (valid_1) v1_seen = 1'b1;
        if (mon_en && valid_0) mon_log.push_back({1'b0, rData_port_0});
        if (mon_en && valid_1) mon_log.push_back({1'b1, rData_port_1});
    end

    task automatic tick;
        @(posedge medClk);
        #1;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        tick();
        tick();
        tests_run++; if (romAddr !== 16'h0) begin failed++; $display("FAIL reset_romAddr got %h exp 0000", romAddr); end
        tests_run++; if ({valid_0, valid_1, busy, done} !== 4'b0) begin failed++; $display("FAIL reset_flags got %b exp 0000", {valid_0, valid_1, busy, done}); end
        tests_run++; if ({rData_port_0, rData_port_1} !== 52'h0) begin failed++; $display("FAIL reset_data got %h/%h exp 0/0", rData_port_0, rData_port_1); end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [15:0] exp_addr [4];
        exp_addr = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        v1_seen = 1'b0;
        baseAddr = 16'h0010; wordCount = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL single_busy got %b exp 1", busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (romAddr !== exp_addr[i]) begin failed++; $display("FAIL single_addr%0d got %h exp %h", i, romAddr, exp_addr[i]); end
        end
        tick();
        tests_run++; if (valid_0 !== 1'b0) begin failed++; $display("FAIL single_early_valid got %b exp 0", valid_0); end
        tick();
        tests_run++; if (valid_0 !== 1'b1) begin failed++; $display("FAIL single_valid got %b exp 1", valid_0); end
        tests_run++; if (rData_port_0 !== 26'h3123456) begin failed++; $display("FAIL single_data got %h exp 3123456", rData_port_0); end
        tick(); tick();
        tests_run++; if ({valid_0, rData_port_0} !== {1'b1, 26'h3123456}) begin failed++; $display("FAIL single_hold got %b/%h exp 1/3123456", valid_0, rData_port_0); end
        ack_0 = 1'b1;
        tick();
        ack_0 = 1'b0;
        tests_run++; if ({done, valid_0} !== 2'b10) begin failed++; $display("FAIL single_done got %b exp 10", {done, valid_0}); end
        tick();
        tests_run++; if ({done, busy} !== 2'b00) begin failed++; $display("FAIL single_idle got %b exp 00", {done, busy}); end
        tests_run++; if (v1_seen !== 1'b0) begin failed++; $display("FAIL single_valid1 got %b exp 0", v1_seen); end
    endtask

    task automatic test_alternation;
        baseAddr = 16'h0100; wordCount = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !valid_0; i++) tick();
        tests_run++; if ({valid_0, rData_port_0} !== {1'b1, 26'h1AABBCC}) begin failed++; $display("FAIL alt_w0 got %b/%h exp 1/1aabbcc", valid_0, rData_port_0); end
        ack_1 = 1'b1;
        tick();
        ack_1 = 1'b0;
        tests_run++; if ({valid_0, romAddr} !== {1'b1, 16'h0103}) begin failed++; $display("FAIL alt_ack1_ignored got %b/%h exp 1/0103", valid_0, romAddr); end
        baseAddr = 16'h0010; wordCount = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++; if ({valid_0, rData_port_0, romAddr, done} !== {1'b1, 26'h1AABBCC, 16'h0103, 1'b0}) begin failed++; $display("FAIL alt_start_ignored got %b/%h/%h exp 1/1aabbcc/0103", valid_0, rData_port_0, romAddr); end
        ack_0 = 1'b1;
        tick();
        ack_0 = 1'b0;
        tests_run++; if (valid_0 !== 1'b0) begin failed++; $display("FAIL alt_clear0 got %b exp 0", valid_0); end
        for (int i = 0; i < 20 && !valid_1; i++) tick();
        tests_run++; if ({valid_1, rData_port_1} !== {1'b1, 26'h2112233}) begin failed++; $display("FAIL alt_w1 got %b/%h exp 1/2112233", valid_1, rData_port_1); end
        tests_run++; if ({valid_0, rData_port_0} !== {1'b0, 26'h1AABBCC}) begin failed++; $display("FAIL alt_retain0 got %b/%h exp 0/1aabbcc", valid_0, rData_port_0); end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++; if ({valid_1, rData_port_1, romAddr} !== {1'b1, 26'h2112233, 16'h0107}) begin failed++; $display("FAIL alt_wait%0d got %b/%h/%h exp 1/2112233/0107", i, valid_1, rData_port_1, romAddr); end
        end
        ack_1 = 1'b1;
        tick();
        ack_1 = 1'b0;
        for (int i = 0; i < 20 && !valid_0; i++) tick();
        tests_run++; if ({valid_0, rData_port_0} !== {1'b1, 26'h3445566}) begin failed++; $display("FAIL alt_w2 got %b/%h exp 1/3445566", valid_0, rData_port_0); end
        tests_run++; if ({valid_1, rData_port_1} !== {1'b0, 26'h2112233}) begin failed++; $display("FAIL alt_retain1 got %b/%h exp 0/2112233", valid_1, rData_port_1); end
        ack_0 = 1'b1;
        tick();
        ack_0 = 1'b0;
        tests_run++; if (done !== 1'b1) begin failed++; $display("FAIL alt_done got %b exp 1", done); end
        tick();
    endtask

    task automatic test_wrap_zero;
        logic [15:0] exp_addr [4];
        exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        baseAddr = 16'hFFFE; wordCount = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (romAddr !== exp_addr[i]) begin failed++; $display("FAIL wrap_addr%0d got %h exp %h", i, romAddr, exp_addr[i]); end
        end
        tick(); tick();
        tests_run++; if ({valid_0, rData_port_0} !== {1'b1, 26'h2ABCDEF}) begin failed++; $display("FAIL wrap_data got %b/%h exp 1/2abcdef", valid_0, rData_port_0); end
        ack_0 = 1'b1;
        tick();
        ack_0 = 1'b0;
        tick();
        baseAddr = 16'h5555; wordCount = 8'd0; start = 1'b1;
        tick();
        tests_run++; if ({busy, done, valid_0, valid_1, romAddr} !== {4'b1100, 16'h0001}) begin failed++; $display("FAIL zero_pulse got %b/%h exp 1100/0001", {busy, done, valid_0, valid_1}, romAddr); end
        wordCount = 8'd1;
        tick();
        start = 1'b0;
        tests_run++; if ({busy, done} !== 2'b00) begin failed++; $display("FAIL zero_start_on_done got %b exp 00", {busy, done}); end
        tick();
        tests_run++; if ({busy, done, romAddr} !== {2'b00, 16'h0001}) begin failed++; $display("FAIL zero_idle got %b/%h exp 00/0001", {busy, done}, romAddr); end
    endtask

    task automatic test_ack_held;
        logic [26:0] exp_log [3];
        exp_log = '{{1'b0, 26'h1AABBCC}, {1'b1, 26'h2112233}, {1'b0, 26'h3445566}};
        mon_log.delete();
        mon_en = 1'b1;
        ack_0 = 1'b1; ack_1 = 1'b1;
        baseAddr = 16'h0100; wordCount = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 80 && !done; i++) tick();
        tests_run++; if (done !== 1'b1) begin failed++; $display("FAIL held_done got %b exp 1", done); end
        ack_0 = 1'b0; ack_1 = 1'b0;
        tick();
        mon_en = 1'b0;
        tests_run++; if (mon_log.size() !== 3) begin failed++; $display("FAIL held_count got %0d exp 3", mon_log.size()); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (i >= mon_log.size() || mon_log[i] !== exp_log[i]) begin failed++; $display("FAIL held_word%0d got %h exp %h", i, i < mon_log.size() ? mon_log[i] : 27'h0, exp_log[i]); end
        end
    endtask

    task automatic test_reset_mid;
        baseAddr = 16'h0100; wordCount = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !valid_0; i++) tick();
        ack_0 = 1'b1;
        tick();
        ack_0 = 1'b0;
        tick(); tick();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tests_run++; if ({valid_0, valid_1, busy, romAddr} !== {3'b000, 16'h0}) begin failed++; $display("FAIL mid_reset got %b/%h exp 000/0000", {valid_0, valid_1, busy}, romAddr); end
        tests_run++; if ({rData_port_0, rData_port_1} !== 52'h0) begin failed++; $display("FAIL mid_reset_data got %h/%h exp 0/0", rData_port_0, rData_port_1); end
        baseAddr = 16'h0010; wordCount = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !(valid_0 || valid_1); i++) tick();
        tests_run++; if ({valid_0, valid_1, rData_port_0} !== {2'b10, 26'h3123456}) begin failed++; $display("FAIL mid_restart got %b/%h exp 10/3123456", {valid_0, valid_1}, rData_port_0); end
        ack_0 = 1'b1;
        tick();
        ack_0 = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        {rom[16'h0010], rom[16'h0011], rom[16'h0012], rom[16'h0013]} = 32'hFF123456;
        {rom[16'h0100], rom[16'h0101], rom[16'h0102], rom[16'h0103]} = 32'h01AABBCC;
        {rom[16'h0104], rom[16'h0105], rom[16'h0106], rom[16'h0107]} = 32'h02112233;
        {rom[16'h0108], rom[16'h0109], rom[16'h010A], rom[16'h010B]} = 32'h07445566;
        {rom[16'hFFFE], rom[16'hFFFF], rom[16'h0000], rom[16'h0001]} = 32'h02ABCDEF;
        rstN = 1'b0; start = 1'b0; ack_0 = 1'b0; ack_1 = 1'b0;
        baseAddr = '0; wordCount = '0; v1_seen = 1'b0; mon_en = 1'b0;
        test_reset();
        test_single();
        test_alternation();
        test_wrap_zero();
        test_ack_held();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
